// File: rtl/imm_extend_pipe.sv
// rtl/imm_extend_pipe.sv - registered immediate-extension stage with valid/ready handshake
// Define IMM_EXT_SKID_EN to add the skid register and registered ready_o.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [OUT_W-1:0] data_o
);
    localparam int E = OUT_W - IN_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] sext, ext;
    logic             accept, xfer;

    always_comb begin
        sext = {{E{data_i[IN_W-1]}}, data_i};
        case (mode_i)
            2'b00:   ext = sext;
            2'b01:   ext = {{E{1'b0}}, data_i};
            2'b10:   ext = {data_i, {E{1'b0}}};
            default: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

    assign accept  = valid_i && ready_o;
    assign xfer    = valid_o && ready_i;
    assign valid_o = (state_q != EMPTY);
    assign data_o  = out_q;

`ifdef IMM_EXT_SKID_EN
    logic [OUT_W-1:0] skid_q, skid_d;
    logic             ready_q, ready_d;

    assign ready_o = ready_q;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    out_d   = ext;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    state_d = TWO;
                    skid_d  = ext;
                end else if (accept) begin
                    out_d = ext;
                end else if (xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins over any same-cycle accept or transfer.
        if (flush_i) state_d = EMPTY;
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end
`else
    assign ready_o = !valid_o || ready_i;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        if (accept) begin
            state_d = ONE;
            out_d   = ext;
        end else if (xfer) begin
            state_d = EMPTY;
        end
        if (flush_i) state_d = EMPTY;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb/tb_imm_extend_pipe.sv - scoreboard bench for imm_extend_pipe
module tb_imm_extend_pipe;
    logic        clk_i, rst_i, flush_i, valid_i, ready_i;
    logic        ready_o, valid_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic [31:0] data_o;

    int checks = 0;
    int fails  = 0;
    int run_len = 0;
    int max_run = 0;
    int xfers = 0;
    bit stall_prev = 0;
    bit flush_prev = 0;
    bit rnd_done = 0;
    logic [31:0] prev_data = '0;
    logic [31:0] exp_q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i), .mode_i(mode_i),
        .valid_o(valid_o), .ready_i(ready_i), .data_o(data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference: treat the immediate as a number and extend arithmetically.
    function automatic logic [31:0] ref_ext(input logic [15:0] d, input logic [1:0] m);
        int s;
        s = d[15] ? int'(d) - 65536 : int'(d);
        case (m)
            2'd0:    return 32'(s);
            2'd1:    return 32'(int'(d));
            2'd2:    return 32'(int'(d)) * 32'd65536;
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [15:0] d, input logic [1:0] m);
        int n;
        n = 0;
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        @(negedge clk_i);
        while (!ready_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        chk("send_accept", 32'(ready_o), 32'd1);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i) begin
            exp_q.delete();
            stall_prev = 0;
            flush_prev = 0;
            run_len = 0;
        end else begin
            if (stall_prev && !flush_prev) begin
                chk("hold_valid", 32'(valid_o), 32'd1);
                chk("hold_data", data_o, prev_data);
            end
            run_len = valid_o ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (flush_i) begin
                exp_q.delete();
            end else begin
                if (valid_o && ready_i) begin
                    xfers++;
                    if (exp_q.size() == 0)
                        chk("unexpected_output", 32'(valid_o), 32'd0);
                    else
                        chk("scoreboard_data", data_o, exp_q.pop_front());
                end
                if (valid_i && ready_o) exp_q.push_back(ref_ext(data_i, mode_i));
            end
            stall_prev = valid_o && !ready_i;
            prev_data  = data_o;
            flush_prev = flush_i;
        end
    end

    initial begin
        int  t0, x0, n;
        logic [15:0] d;
        logic [1:0]  m;
        rst_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        data_i = '0; mode_i = '0;
        #1;
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_data", data_o, 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Sign extension with one-edge latency, then the other modes.
        send(16'h8004, 2'd0);
        chk("s1_valid", 32'(valid_o), 32'd1);
        chk("s1_data", data_o, 32'hFFFF8004);
        send(16'hFFFE, 2'd1);
        chk("s2_zero", data_o, 32'h0000FFFE);
        send(16'hFFFE, 2'd2);
        chk("s2_upper", data_o, 32'hFFFE0000);
        send(16'hFFFE, 2'd3);
        chk("s2_shift", data_o, 32'hFFFFFFF8);
        cycles(2);

        // Back-pressure: two values held, released in order.
        ready_i = 1'b0;
        send(16'h0001, 2'd1);
`ifdef IMM_EXT_SKID_EN
        send(16'h0002, 2'd1);
        @(negedge clk_i);
        chk("s3_ready_low", 32'(ready_o), 32'd0);
        chk("s3_head", data_o, 32'h1);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
`else
        @(negedge clk_i);
        chk("s3_ready_low", 32'(ready_o), 32'd0);
        @(posedge clk_i); #1;
        ready_i = 1'b1;
        send(16'h0002, 2'd1);
`endif
        cycles(3);
        chk("s3_ready_back", 32'(ready_o), 32'd1);
        chk("s3_drained", 32'(exp_q.size()), 32'd0);

        // Streaming: eight values, no bubbles.
        max_run = 0;
        x0 = xfers;
        t0 = int'($time);
        for (int i = 0; i < 8; i++) send(16'(16'h0100 + i), 2'(i));
        chk("s4_no_stall", 32'(int'($time) - t0), 32'd80);
        cycles(3);
        chk("s4_count", 32'(xfers - x0), 32'd8);
        chk("s4_run", 32'(max_run), 32'd8);

        // Flush while full, with a simultaneous offer.
        ready_i = 1'b0;
        send(16'hAAAA, 2'd0);
`ifdef IMM_EXT_SKID_EN
        send(16'hBBBB, 2'd0);
`endif
        flush_i = 1'b1; valid_i = 1'b1; data_i = 16'hCCCC; mode_i = 2'd0;
        @(posedge clk_i); #1;
        flush_i = 1'b0; valid_i = 1'b0;
        chk("s5_valid", 32'(valid_o), 32'd0);
        chk("s5_ready", 32'(ready_o), 32'd1);
        ready_i = 1'b1;
        x0 = xfers;
        cycles(4);
        chk("s5_nothing_out", 32'(xfers - x0), 32'd0);

        // Asynchronous reset between edges mid-stream.
        send(16'h1234, 2'd1);
        send(16'h4321, 2'd1);
        send(16'h7777, 2'd2);
        valid_i = 1'b1; data_i = 16'h5555; mode_i = 2'd1;
        #2;
        rst_i = 1'b0;
        #1;
        chk("s6_valid", 32'(valid_o), 32'd0);
        chk("s6_data", data_o, 32'd0);
        chk("s6_ready", 32'(ready_o), 32'd1);
        valid_i = 1'b0;
        @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        send(16'h8004, 2'd0);
        chk("s6_valid_after", 32'(valid_o), 32'd1);
        chk("s6_data_after", data_o, 32'hFFFF8004);
        cycles(2);

        // Random traffic with random back-pressure and occasional flush.
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 31) == 0) begin
                        flush_i = 1'b1;
                        valid_i = 1'($urandom_range(0, 1));
                        data_i  = 16'($urandom);
                        mode_i  = 2'($urandom_range(0, 3));
                        @(posedge clk_i); #1;
                        flush_i = 1'b0;
                        valid_i = 1'b0;
                    end
                    d = 16'($urandom);
                    m = 2'($urandom_range(0, 3));
                    send(d, m);
                    if ($urandom_range(0, 3) == 0) cycles(1);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk_i); #1;
                    ready_i = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ready_i = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            cycles(1);
        end
        cycles(2);
        chk("final_drained", 32'(exp_q.size()), 32'd0);
        chk("final_valid", 32'(valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
